lcd_timing_gen: RTL

- Timing generator that sits directly upstream of the colour-bar / pattern stage for the 800x480 LCD panel.
- Divides CLK by 2 to produce the panel clock NCLK.
- Runs the horizontal and vertical counters and drives the panel sync signals HD, VD, DEN and the panel reset GREST.
- Exports the active-area pixel coordinates COL/ROW plus a pixel-advance strobe, so the pattern stage only maps coordinates to R/G/B.

---
 rtl/lcd_timing_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lcd_timing_gen.sv
// Panel timing generator for the 800x480 LCD: divides CLK by 2 into NCLK, runs the
// horizontal/vertical counters and drives HD/VD/DEN/GREST plus active-area COL/ROW.
module lcd_timing_gen #(
  parameter int unsigned H_ACT   = 800,
  parameter int unsigned H_FP    = 210,
  parameter int unsigned H_PULSE = 30,
  parameter int unsigned H_BP    = 16,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned V_FP    = 22,
  parameter int unsigned V_PULSE = 13,
  parameter int unsigned V_BP    = 10,
  parameter int unsigned HW      = 11,
  parameter int unsigned VW      = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_nclk,
  output logic          o_grest,
  output logic          o_hd,
  output logic          o_vd,
  output logic          o_den,
  output logic [HW-1:0] o_col,
  output logic [VW-1:0] o_row,
  output logic          o_pix_tick,
  output logic          o_frame_start
);

  localparam int unsigned H_TOTAL = H_PULSE + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOTAL = V_PULSE + V_BP + V_ACT + V_FP;

  localparam logic [HW-1:0] L_H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] L_H_PULSE = HW'(H_PULSE);
  localparam logic [HW-1:0] L_H_START = HW'(H_PULSE + H_BP);
  localparam logic [HW-1:0] L_H_END   = HW'(H_PULSE + H_BP + H_ACT);
  localparam logic [VW-1:0] L_V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] L_V_PULSE = VW'(V_PULSE);
  localparam logic [VW-1:0] L_V_START = VW'(V_PULSE + V_BP);
  localparam logic [VW-1:0] L_V_END   = VW'(V_PULSE + V_BP + V_ACT);

  logic          r_phase;
  logic          r_grest;
  logic          r_hd;
  logic          r_vd;
  logic          r_den;
  logic [HW-1:0] r_col;
  logic [VW-1:0] r_row;
  logic          r_pix_tick;
  logic          r_frame_start;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  logic          w_tick;
  logic          w_h_wrap;
  logic          w_frame_wrap;
  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] w_v_nxt;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_den_nxt;
  logic [HW-1:0] w_col_nxt;
  logic [VW-1:0] w_row_nxt;

  // Counters advance when phase falls 1->0, i.e. the cycle in which NCLK goes low.
  always_comb begin
    w_tick       = r_phase;
    w_h_wrap     = (r_h_cnt == L_H_LAST);
    w_frame_wrap = w_h_wrap && (r_v_cnt == L_V_LAST);
    w_h_nxt      = w_h_wrap ? '0 : r_h_cnt + HW'(1);
    w_v_nxt      = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = (r_v_cnt == L_V_LAST) ? '0 : r_v_cnt + VW'(1);
    end
    w_h_act   = (w_h_nxt >= L_H_START) && (w_h_nxt < L_H_END);
    w_v_act   = (w_v_nxt >= L_V_START) && (w_v_nxt < L_V_END);
    w_den_nxt = w_h_act && w_v_act;
    w_col_nxt = w_den_nxt ? (w_h_nxt - L_H_START) : '0;
    // ROW keeps the last active row through blanking inside the active lines.
    w_row_nxt = '0;
    if (w_v_act) begin
      w_row_nxt = w_den_nxt ? (w_v_nxt - L_V_START) : r_row;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase       <= 1'b0;
      r_grest       <= 1'b0;
      r_hd          <= 1'b1;
      r_vd          <= 1'b1;
      r_den         <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_pix_tick    <= 1'b0;
      r_frame_start <= 1'b0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
    end else begin
      r_phase       <= ~r_phase;
      r_grest       <= 1'b1;
      r_pix_tick    <= w_tick;
      r_frame_start <= w_tick && w_frame_wrap;
      if (w_tick) begin
        r_h_cnt <= w_h_nxt;
        r_v_cnt <= w_v_nxt;
        r_hd    <= !(w_h_nxt < L_H_PULSE);
        r_vd    <= !(w_v_nxt < L_V_PULSE);
        r_den   <= w_den_nxt;
        r_col   <= w_col_nxt;
        r_row   <= w_row_nxt;
      end
    end
  end

  assign o_nclk        = r_phase;
  assign o_grest       = r_grest;
  assign o_hd          = r_hd;
  assign o_vd          = r_vd;
  assign o_den         = r_den;
  assign o_col         = r_col;
  assign o_row         = r_row;
  assign o_pix_tick    = r_pix_tick;
  assign o_frame_start = r_frame_start;

endmodule
